mul_share_ctrl: RTL and testbench
=================================

// Module: mul_share_ctrl
// PURPOSE
//  Shares one 32x32 signed multi-cycle Booth multiplier (start/valid, 64b Z) among NREQ requesters.
//  Round-robin arbitration; holds operands stable for the whole multiply; supports the RISC-V
//  M-extension ops MUL/MULH/MULHSU/MULHU via unsigned correction of the signed product.
//  Returns 32b results on a per-requester valid/ready handshake. A watchdog reports a stalled multiplier.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  TIMEOUT  64  cycles from mul_start to the missing mul_valid that signal an error (> 34)
//  COOL     40  cycles of quiet after a timeout before the next issue
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-low reset
//  req_valid  in   NREQ     request pending, one per requester
//  req_ready  out  NREQ     request accepted this cycle (one-hot or zero)
//  req_op     in   2*NREQ   per requester: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  req_a      in   32*NREQ  rs1 operand per requester
//  req_b      in   32*NREQ  rs2 operand per requester
//  resp_valid out  NREQ     result valid for the owning requester (one-hot or zero)
//  resp_ready in   NREQ     requester accepts the result
//  resp_data  out  32       result word (shared bus)
//  resp_err   out  1        qualifies resp_valid: timeout; resp_data = 0
//  mul_start  out  1        one-cycle start pulse to the multiplier
//  mul_x      out  32       multiplicand X; held stable from mul_start until mul_valid/timeout
//  mul_y      out  32       multiplier Y; held stable likewise
//  mul_z      in   64       signed product, sampled only when mul_valid=1
//  mul_valid  in   1        one-cycle product-valid pulse
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): state IDLE; rr pointer=0; req_ready, resp_valid, mul_start = 0;
//   resp_data, resp_err, mul_x, mul_y = 0; watchdog=0. Reset mid-operation abandons the job; no response.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; WAIT -> RESP(err) -> COOL -> IDLE on timeout.
//  IDLE: when any req_valid, grant g = first set bit at or after rr pointer (wrapping).
//   Assert req_ready[g] for that one cycle; latch a, b, op, g. Go to ISSUE.
//  ISSUE: mul_start=1 for exactly one cycle; mul_x=a, mul_y=b (registered, constant until leaving WAIT).
//   Clear the watchdog. Go to WAIT.
//  WAIT: the watchdog increments each cycle. On mul_valid: compute the result, go to RESP.
//   If the watchdog reaches TIMEOUT first: resp_err=1, resp_data=0, go to RESP and then COOL.
//   Nominal latency, req accept -> resp_valid: 36 cycles (1 ISSUE + 33 multiplier + 1 capture + 1 reg).
//  Result (P = mul_z, Hs = P[63:32]):
//   MUL    -> P[31:0]
//   MULH   -> Hs
//   MULHSU -> Hs + (b[31] ? a : 0)
//   MULHU  -> Hs + (a[31] ? b : 0) + (b[31] ? a : 0)
//   All sums are mod 2^32.
//  RESP: resp_valid[g]=1, with resp_data/resp_err stable until resp_ready[g]=1. At that edge:
//   rr pointer = (g+1) mod NREQ; next state IDLE (or COOL if err). No new grant in the same cycle.
//  COOL: wait COOL cycles, ignoring mul_valid, so that an in-flight multiply drains. Then IDLE.
//  mul_valid in IDLE, ISSUE, RESP or COOL is ignored (stray pulse after a reset or timeout).
//  A requester dropping req_valid before it is granted is legal; req_ready is only given to a valid request.
//  Only one job is in flight; all other requesters see req_ready=0 until the FSM returns to IDLE.
// STRUCTURE
//  Package mul_share_pkg: op encodings (OP_MUL..OP_MULHU), state enum (IDLE/ISSUE/WAIT/RESP/COOL),
//   correction function hi_fix(op, a, b, hs).
//  Sub-module rr_arbiter #(N): inputs req, ptr; output one-hot gnt. Purely combinational;
//   the pointer lives in mul_share_ctrl. The multiplier is instantiated outside this block.
// TESTING
//  Bench uses the real Booth multiplier model; it checks against a 64b reference product.
//  1. Req0 MUL a=3, b=5 -> one mul_start pulse; resp_valid[0] after 36 cycles; data=0x0000000F.
//  2. MULH a=b=0xFFFFFFFF -> 0x00000000. MULHSU same operands -> 0xFFFFFFFF.
//     MULHU same operands -> 0xFFFFFFFE.
//  3. All 4 requesters hold req_valid -> grant order 0,1,2,3,0. mul_x/mul_y are constant across each WAIT.
//  4. resp_ready held low 10 cycles -> resp_valid and resp_data held; no new req_ready until it is accepted.
//  5. Multiplier stub never pulses mul_valid -> resp_err=1, data=0 at TIMEOUT. No grant for COOL cycles.
//     A stray mul_valid during COOL is ignored.
//  6. rst=0 for one cycle mid-WAIT -> outputs reset; the late mul_valid is ignored.
//     A new request completes correctly.

Source files
------------

// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared encodings, FSM states and result correction for mul_share_ctrl
//
// Contents:
//   OP_MUL .. OP_MULHU  2-bit operation encodings carried on req_op
//   state_t             controller states
//   hi_fix()            turns the signed high word into MULH/MULHSU/MULHU results

package mul_share_pkg;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_COOL
   } state_t;

   // The shared multiplier only produces the signed x signed product.
   // Reinterpreting an operand as unsigned adds 2^32 * operand when its
   // sign bit is set, which in the high word is just "+ other operand".
   // The 2^64 cross term of MULHU falls off the top. Sums wrap mod 2^32.
   function automatic logic [31:0] hi_fix(input logic [1:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] hs);
      logic [31:0] fix_a;
      logic [31:0] fix_b;
      fix_a = ((op == OP_MULHU) && a[31]) ? b : 32'd0;
      fix_b = (((op == OP_MULHU) || (op == OP_MULHSU)) && b[31]) ? a : 32'd0;
      return hs + fix_a + fix_b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
//
// Ports:
//   req  in   N        pending requests
//   ptr  in   PW       highest-priority index this round (0..N-1)
//   gnt  out  N        one-hot grant of the first set req at or after ptr, wrapping; zero if none

module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   localparam int PW1 = PW + 1;

   // One extra bit: ptr + i peaks at 2N-2, which needs PW+1 bits.
   logic [PW:0]   sum;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + PW1'(i);
         if (sum >= PW1'(N)) begin
            sum = sum - PW1'(N);
         end
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one multi-cycle signed multiplier among NREQ requesters
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous active-low reset
//   req_valid   in   NREQ     request pending per requester
//   req_ready   out  NREQ     request accepted this cycle (one-hot or zero)
//   req_op      in   2*NREQ   per requester: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_a       in   32*NREQ  rs1 per requester
//   req_b       in   32*NREQ  rs2 per requester
//   resp_valid  out  NREQ     result valid to the owning requester (one-hot or zero)
//   resp_ready  in   NREQ     requester takes the result
//   resp_data   out  32       shared result bus
//   resp_err    out  1        multiplier timed out; resp_data is 0
//   mul_start   out  1        one-cycle start pulse
//   mul_x       out  32       multiplicand, held for the whole multiply
//   mul_y       out  32       multiplier, held for the whole multiply
//   mul_z       in   64       signed product, used only with mul_valid
//   mul_valid   in   1        one-cycle product-valid pulse

module mul_share_ctrl
   import mul_share_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64,
   parameter int COOL    = 40
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [31:0]          resp_data,
   output logic                 resp_err,
   output logic                 mul_start,
   output logic [31:0]          mul_x,
   output logic [31:0]          mul_y,
   input  logic [63:0]          mul_z,
   input  logic                 mul_valid
);

   localparam int PW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int CW = $clog2(COOL + 1);

   state_t          state_q;
   state_t          state_d;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   gidx_q;
   logic [PW-1:0]   gidx_sel;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] gnt_q;
   logic [1:0]      op_q;
   logic [1:0]      op_sel;
   logic [31:0]     a_sel;
   logic [31:0]     b_sel;
   logic [63:0]     z_q;
   logic            cap_q;
   logic [WW-1:0]   wd_q;
   logic [CW-1:0]   cool_q;
   logic [31:0]     result;

   logic            accept;
   logic            capture;
   logic            finish;
   logic            timeout;
   logic            resp_done;

   rr_arbiter #(
      .N  (NREQ),
      .PW (PW)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt)
   );

   // Operand mux for the granted requester.
   always_comb begin
      a_sel    = '0;
      b_sel    = '0;
      op_sel   = OP_MUL;
      gidx_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            a_sel    = req_a[32*i +: 32];
            b_sel    = req_b[32*i +: 32];
            op_sel   = req_op[2*i +: 2];
            gidx_sel = PW'(i);
         end
      end
   end

   // mul_x/mul_y double as the latched rs1/rs2 for the correction terms.
   assign result = (op_q == OP_MUL) ? z_q[31:0] : hi_fix(op_q, mul_x, mul_y, z_q[63:32]);

   // Grants are suppressed while reset is held so no handshake is lost.
   assign req_ready  = ((state_q == ST_IDLE) && rst) ? gnt : '0;
   assign resp_valid = (state_q == ST_RESP) ? gnt_q : '0;
   assign mul_start  = (state_q == ST_ISSUE);

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      capture   = 1'b0;
      finish    = 1'b0;
      timeout   = 1'b0;
      resp_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               accept  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Product is captured first, the corrected result registered a cycle later.
            if (cap_q) begin
               finish  = 1'b1;
               state_d = ST_RESP;
            end else if (mul_valid) begin
               capture = 1'b1;
            end else if (wd_q == WW'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (|(resp_ready & gnt_q)) begin
               resp_done = 1'b1;
               state_d   = resp_err ? ST_COOL : ST_IDLE;
            end
         end
         ST_COOL: begin
            // Lets a late product from the timed-out job drain unseen.
            if (cool_q == CW'(COOL - 1)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         gnt_q     <= '0;
         op_q      <= OP_MUL;
         mul_x     <= '0;
         mul_y     <= '0;
         z_q       <= '0;
         cap_q     <= 1'b0;
         wd_q      <= '0;
         cool_q    <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else begin
         state_q <= state_d;

         if (accept) begin
            mul_x  <= a_sel;
            mul_y  <= b_sel;
            op_q   <= op_sel;
            gidx_q <= gidx_sel;
            gnt_q  <= gnt;
         end

         if (state_q == ST_ISSUE) begin
            wd_q  <= '0;
            cap_q <= 1'b0;
         end else if (state_q == ST_WAIT) begin
            wd_q <= wd_q + WW'(1);
         end

         if (capture) begin
            z_q   <= mul_z;
            cap_q <= 1'b1;
         end

         if (finish) begin
            resp_data <= result;
            resp_err  <= 1'b0;
         end

         if (timeout) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
         end

         if (resp_done) begin
            ptr_q     <= (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
            resp_data <= '0;
            resp_err  <= 1'b0;
         end

         if (state_q == ST_COOL) begin
            cool_q <= cool_q + CW'(1);
         end else begin
            cool_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - directed self-checking bench for mul_share_ctrl with a radix-2 Booth multiplier model

module tb_mul_share_ctrl;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;
   localparam int COOL    = 40;

   localparam logic [1:0] T_MUL    = 2'b00;
   localparam logic [1:0] T_MULH   = 2'b01;
   localparam logic [1:0] T_MULHSU = 2'b10;
   localparam logic [1:0] T_MULHU  = 2'b11;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [2*NREQ-1:0]    req_op = '0;
   logic [32*NREQ-1:0]   req_a = '0;
   logic [32*NREQ-1:0]   req_b = '0;
   logic [NREQ-1:0]      resp_valid;
   logic [NREQ-1:0]      resp_ready = '0;
   logic [31:0]          resp_data;
   logic                 resp_err;
   logic                 mul_start;
   logic [31:0]          mul_x;
   logic [31:0]          mul_y;
   logic [63:0]          mul_z;
   logic                 mul_valid;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   mul_share_ctrl #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT),
      .COOL    (COOL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .mul_start  (mul_start),
      .mul_x      (mul_x),
      .mul_y      (mul_y),
      .mul_z      (mul_z),
      .mul_valid  (mul_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Booth multiplier model: 33-bit accumulator so -2^31 operands cannot overflow.
   // Start seen at one edge, 32 steps on the following edges, valid on the 33rd cycle.
   // It ignores the controller reset so an abandoned job still pulses late.
   logic        m_dead  = 1'b0;
   logic        stray   = 1'b0;
   logic [63:0] stray_z = 64'hDEAD_BEEF_0BAD_F00D;
   logic        m_busy  = 1'b0;
   logic        m_valid = 1'b0;
   logic [5:0]  m_cnt   = '0;
   logic [65:0] m_p     = '0;
   logic [31:0] m_x     = '0;
   logic [63:0] m_z     = '0;
   logic [65:0] m_pn;
   int          starts  = 0;

   function automatic logic [65:0] booth_step(input logic [65:0] p, input logic [31:0] x);
      logic [65:0] t;
      t = p;
      case (p[1:0])
         2'b01:   t[65:33] = p[65:33] + {x[31], x};
         2'b10:   t[65:33] = p[65:33] - {x[31], x};
         default: t = p;
      endcase
      return {t[65], t[65:1]};
   endfunction

   assign m_pn = booth_step(m_p, m_x);

   always @(posedge clk) begin
      m_valid <= 1'b0;
      if (mul_start) starts <= starts + 1;
      if (mul_start && !m_dead) begin
         m_busy <= 1'b1;
         m_cnt  <= '0;
         m_x    <= mul_x;
         m_p    <= {33'd0, mul_y, 1'b0};
      end else if (m_busy) begin
         m_p   <= m_pn;
         m_cnt <= m_cnt + 6'd1;
         if (m_cnt == 6'd31) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
            m_z     <= m_pn[64:1];
         end
      end
   end

   assign mul_valid = m_valid | stray;
   assign mul_z     = stray ? stray_z : m_z;

   task automatic start_req(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[2*r +: 2]  = op;
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      req_valid[r]      = 1'b1;
   endtask

   // Returns at the negedge after the accepting edge; who=-1 if no grant came.
   task automatic wait_grant(output int who, output int t_acc);
      who   = -1;
      t_acc = 0;
      for (int i = 0; i < 200 && who < 0; i++) begin
         #1;
         for (int j = 0; j < NREQ; j++) if (req_ready[j]) who = j;
         if (who >= 0) t_acc = cyc + 1;
         @(negedge clk);
      end
   endtask

   task automatic collect(input int r, input int hold, input logic [31:0] ea, input logic [31:0] eb,
                          input int t_acc, output bit ok, output int lat, output logic [31:0] d,
                          output logic e, output bit held, output bit xy_ok);
      logic [NREQ-1:0] onehot;
      onehot    = '0;
      onehot[r] = 1'b1;
      ok = 0; held = 1; xy_ok = 1; lat = 0; d = '0; e = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (resp_valid[r] === 1'b1) ok = 1;
         else begin
            if (mul_x !== ea || mul_y !== eb) xy_ok = 0;
            @(negedge clk);
         end
      end
      if (ok) begin
         lat = cyc + 1 - t_acc;
         d   = resp_data;
         e   = resp_err;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (resp_valid !== onehot || resp_data !== d || resp_err !== e || req_ready !== '0) held = 0;
         end
         resp_ready[r] = 1'b1;
         @(negedge clk);
         resp_ready[r] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      req_valid = '1;
      repeat (3) @(negedge clk);
      #1;
      total++; if (req_ready !== '0)   begin bad++; $display("FAIL reset_req_ready got=%h want=0", req_ready); end
      total++; if (resp_valid !== '0)  begin bad++; $display("FAIL reset_resp_valid got=%h want=0", resp_valid); end
      total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start got=%b want=0", mul_start); end
      total++; if (resp_data !== '0)   begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
      total++; if (resp_err !== 1'b0)  begin bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
      total++; if (mul_x !== '0 || mul_y !== '0) begin bad++; $display("FAIL reset_mul_xy got=%h/%h want=0/0", mul_x, mul_y); end
      req_valid = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_rr();
      logic [31:0] ea[4];
      logic [31:0] eb[4];
      logic [31:0] ed[4];
      logic [1:0]  eo[4];
      int          order[5];
      int who, t_acc, lat;
      bit ok, held, xy_ok;
      logic [31:0] d;
      logic e;
      ea    = '{32'd2, 32'd3, 32'h0001_0000, 32'hFFFF_FFFF};
      eb    = '{32'd7, 32'h11, 32'h0001_0000, 32'd2};
      eo    = '{T_MUL, T_MUL, T_MULHU, T_MULH};
      ed    = '{32'd14, 32'h33, 32'h1, 32'hFFFF_FFFF};
      order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NREQ; i++) start_req(i, eo[i], ea[i], eb[i]);
      for (int k = 0; k < 5; k++) begin
         wait_grant(who, t_acc);
         total++; if (who !== order[k]) begin bad++; $display("FAIL rr_grant%0d got=%0d want=%0d", k, who, order[k]); end
         if (who < 0) break;
         if (k == 4) req_valid = '0;
         collect(who, 0, ea[who], eb[who], t_acc, ok, lat, d, e, held, xy_ok);
         total++; if (!ok)          begin bad++; $display("FAIL rr_resp%0d got=none want=resp_valid", k); end
         total++; if (d !== ed[who]) begin bad++; $display("FAIL rr_data%0d got=%h want=%h", k, d, ed[who]); end
         total++; if (!xy_ok)        begin bad++; $display("FAIL rr_xy_stable%0d got=changed want=%h/%h", k, ea[who], eb[who]); end
      end
      req_valid = '0;
   endtask

   task automatic test_basic();
      int who, t_acc, lat, s0;
      bit ok, held, xy_ok;
      logic [31:0] d;
      logic e;
      s0 = starts;
      start_req(0, T_MUL, 32'd3, 32'd5);
      wait_grant(who, t_acc);
      req_valid[0] = 1'b0;
      total++; if (who !== 0) begin bad++; $display("FAIL basic_grant got=%0d want=0", who); end
      collect(0, 0, 32'd3, 32'd5, t_acc, ok, lat, d, e, held, xy_ok);
      total++; if (!ok)                 begin bad++; $display("FAIL basic_resp got=none want=resp_valid"); end
      total++; if (lat !== 36)          begin bad++; $display("FAIL basic_latency got=%0d want=36", lat); end
      total++; if (d !== 32'h0000_000F) begin bad++; $display("FAIL basic_data got=%h want=0000000f", d); end
      total++; if (e !== 1'b0)          begin bad++; $display("FAIL basic_err got=%b want=0", e); end
      total++; if (starts - s0 !== 1)   begin bad++; $display("FAIL basic_start_pulses got=%0d want=1", starts - s0); end
   endtask

   task automatic test_ops();
      logic [1:0]  vo[11];
      logic [31:0] va[11];
      logic [31:0] vb[11];
      logic [31:0] vd[11];
      int who, t_acc, lat;
      bit ok, held, xy_ok;
      logic [31:0] d;
      logic e;
      vo = '{T_MULH, T_MULHSU, T_MULHU, T_MUL, T_MUL, T_MULH, T_MULHU, T_MULH, T_MULHSU, T_MULHSU, T_MULH};
      va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
             32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFE, 32'h0000_0003, 32'h7FFF_FFFF};
      vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'h8000_0000, 32'h0000_0010, 32'h0000_0003, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
      vd = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000,
             32'h4000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h3FFF_FFFF};
      for (int i = 0; i < 11; i++) begin
         start_req(2, vo[i], va[i], vb[i]);
         wait_grant(who, t_acc);
         req_valid[2] = 1'b0;
         collect(2, 0, va[i], vb[i], t_acc, ok, lat, d, e, held, xy_ok);
         total++; if (!ok || d !== vd[i] || e !== 1'b0)
            begin bad++; $display("FAIL op%0d got=%h err=%b want=%h err=0", i, d, e, vd[i]); end
      end
   endtask

   task automatic test_backpressure();
      int who, t_acc, lat;
      bit ok, held, xy_ok;
      logic [31:0] d;
      logic e;
      start_req(1, T_MUL, 32'd6, 32'd7);
      wait_grant(who, t_acc);
      req_valid[1] = 1'b0;
      total++; if (who !== 1) begin bad++; $display("FAIL bp_grant got=%0d want=1", who); end
      start_req(3, T_MUL, 32'd2, 32'd2);
      collect(1, 10, 32'd6, 32'd7, t_acc, ok, lat, d, e, held, xy_ok);
      total++; if (!ok || d !== 32'd42) begin bad++; $display("FAIL bp_data got=%h want=0000002a", d); end
      total++; if (!held)               begin bad++; $display("FAIL bp_hold got=changed want=held"); end
      wait_grant(who, t_acc);
      req_valid[3] = 1'b0;
      total++; if (who !== 3) begin bad++; $display("FAIL bp_next_grant got=%0d want=3", who); end
      collect(3, 0, 32'd2, 32'd2, t_acc, ok, lat, d, e, held, xy_ok);
      total++; if (!ok || d !== 32'd4) begin bad++; $display("FAIL bp_next_data got=%h want=00000004", d); end
   endtask

   task automatic test_timeout();
      int who, t_acc, lat, t_r;
      bit ok, held, xy_ok, quiet;
      logic [31:0] d;
      logic e;
      m_dead = 1'b1;
      start_req(2, T_MUL, 32'd1, 32'd1);
      wait_grant(who, t_acc);
      req_valid[2] = 1'b0;
      collect(2, 3, 32'd1, 32'd1, t_acc, ok, lat, d, e, held, xy_ok);
      total++; if (!ok)                 begin bad++; $display("FAIL to_resp got=none want=resp_valid"); end
      total++; if (lat !== TIMEOUT + 2) begin bad++; $display("FAIL to_latency got=%0d want=%0d", lat, TIMEOUT + 2); end
      total++; if (e !== 1'b1)          begin bad++; $display("FAIL to_err got=%b want=1", e); end
      total++; if (d !== 32'd0)         begin bad++; $display("FAIL to_data got=%h want=0", d); end
      total++; if (!held)               begin bad++; $display("FAIL to_hold got=changed want=held"); end
      m_dead = 1'b0;
      t_r    = cyc;
      quiet  = 1;
      start_req(0, T_MUL, 32'd4, 32'd4);
      for (int i = 0; i < COOL; i++) begin
         #1;
         if (req_ready !== '0) quiet = 0;
         @(negedge clk);
         if (i == 10) stray = 1'b1;
         if (i == 11) stray = 1'b0;
      end
      total++; if (!quiet) begin bad++; $display("FAIL cool_no_grant got=grant want=none"); end
      wait_grant(who, t_acc);
      req_valid[0] = 1'b0;
      total++; if (who !== 0 || t_acc !== t_r + COOL + 1)
         begin bad++; $display("FAIL cool_grant got=%0d@%0d want=0@%0d", who, t_acc - t_r, COOL + 1); end
      collect(0, 0, 32'd4, 32'd4, t_acc, ok, lat, d, e, held, xy_ok);
      total++; if (!ok || d !== 32'd16 || e !== 1'b0 || lat !== 36)
         begin bad++; $display("FAIL cool_after_data got=%h err=%b lat=%0d want=00000010 err=0 lat=36", d, e, lat); end
   endtask

   task automatic test_reset_mid();
      int who, t_acc, lat;
      bit ok, held, xy_ok, quiet;
      logic [31:0] d;
      logic e;
      start_req(1, T_MUL, 32'd9, 32'd9);
      wait_grant(who, t_acc);
      req_valid[1] = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (resp_valid !== '0 || mul_start !== 1'b0 || resp_err !== 1'b0)
         begin bad++; $display("FAIL rstmid_ctrl got=%h/%b/%b want=0/0/0", resp_valid, mul_start, resp_err); end
      total++; if (mul_x !== '0 || mul_y !== '0 || resp_data !== '0)
         begin bad++; $display("FAIL rstmid_data got=%h/%h/%h want=0/0/0", mul_x, mul_y, resp_data); end
      quiet = 1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (resp_valid !== '0 || mul_start !== 1'b0) quiet = 0;
      end
      total++; if (!quiet) begin bad++; $display("FAIL rstmid_late_valid got=activity want=idle"); end
      start_req(2, T_MUL, 32'h10, 32'h20);
      wait_grant(who, t_acc);
      req_valid[2] = 1'b0;
      total++; if (who !== 2) begin bad++; $display("FAIL rstmid_grant got=%0d want=2", who); end
      collect(2, 0, 32'h10, 32'h20, t_acc, ok, lat, d, e, held, xy_ok);
      total++; if (!ok || d !== 32'h200 || e !== 1'b0 || lat !== 36)
         begin bad++; $display("FAIL rstmid_job got=%h err=%b lat=%0d want=00000200 err=0 lat=36", d, e, lat); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_rr();
      test_basic();
      test_ops();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL sim_time_limit got=expired want=finished");
      $fatal(1);
   end

endmodule
